sipo_word_collector: RTL and testbench

// - Downstream stage of the universal shift register. Consumes its serial output one bit per

---
 rtl/sipo_word_collector_if.sv | 17 +
 rtl/sipo_word_collector.sv | 148 ++++++++++++++
 tb/tb_sipo_word_collector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_word_collector_if.sv
// rtl/sipo_word_collector_if.sv - word output handshake bundle (dout/dout_valid/dout_ready); PARITY_CHECK_EN adds parity_err
interface sipo_word_collector_if #(
   parameter int WIDTH = 4
) ();
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
`ifdef PARITY_CHECK_EN
   logic             parity_err;

   modport master (output dout, output dout_valid, output parity_err, input dout_ready);
   modport slave  (input dout, input dout_valid, input parity_err, output dout_ready);
`else
   modport master (output dout, output dout_valid, input dout_ready);
   modport slave  (input dout, input dout_valid, output dout_ready);
`endif
endinterface

// File: rtl/sipo_word_collector.sv
// rtl/sipo_word_collector.sv - serial-to-parallel word collector with one-word holding stage; PARITY_CHECK_EN enables trailing even-parity bit
module sipo_word_collector #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sin,
   input  logic          sin_en,
   input  logic          clr,
   output logic [CW-1:0] bit_cnt,
   output logic          overrun,
   sipo_word_collector_if.master out_if
);

   localparam logic [1:0]    ST_IDLE  = 2'd0;
   localparam logic [1:0]    ST_SHIFT = 2'd1;
`ifdef PARITY_CHECK_EN
   localparam logic [1:0]    ST_PAR   = 2'd2;
`endif
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             complete;
`ifdef PARITY_CHECK_EN
   logic             perr_q, perr_d;
   logic             par_bad;
`endif

   // Incoming bit merged into the shift register according to bit order
   always_comb begin
      if (LSB_FIRST) shifted = {sin, sreg_q[WIDTH-1:1]};
      else           shifted = {sreg_q[WIDTH-2:0], sin};
   end

   // Framing FSM: counts data bits, detects word completion; clr beats sin_en
   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
      word     = sreg_q;
`ifdef PARITY_CHECK_EN
      par_bad  = 1'b0;
`endif
      if (clr) begin
         cnt_d   = '0;
         state_d = ST_IDLE;
      end else if (sin_en) begin
         case (state_q)
            ST_IDLE: begin
               sreg_d  = shifted;
               cnt_d   = CW'(1);
               state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
               sreg_d = shifted;
               if (cnt_q == LAST_BIT) begin
                  cnt_d = '0;
`ifdef PARITY_CHECK_EN
                  state_d = ST_PAR;
`else
                  complete = 1'b1;
                  word     = shifted;
                  state_d  = ST_IDLE;
`endif
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
`ifdef PARITY_CHECK_EN
            ST_PAR: begin
               complete = 1'b1;
               word     = sreg_q;
               par_bad  = (^sreg_q) ^ sin;
               state_d  = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output holding stage: load when empty or draining, otherwise drop and flag overrun
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
`ifdef PARITY_CHECK_EN
      perr_d  = perr_q;
`endif
      if (complete) begin
         if (!valid_q || out_if.dout_ready) begin
            dout_d  = word;
            valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
            perr_d  = par_bad;
`endif
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && out_if.dout_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign bit_cnt           = cnt_q;
   assign overrun           = ovr_q;
   assign out_if.dout       = dout_q;
   assign out_if.dout_valid = valid_q;
`ifdef PARITY_CHECK_EN
   assign out_if.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_word_collector.sv
// tb/tb_sipo_word_collector.sv - self-checking bench for sipo_word_collector (WIDTH=4, LSB first)
module tb_sipo_word_collector;

   logic       clk;
   logic       rst;
   logic       sin;
   logic       sin_en;
   logic       clr;
   logic [2:0] bit_cnt;
   logic       overrun;

   int n_pass  = 0;
   int n_total = 0;

   logic [3:0] sb[$];

   typedef struct {
      logic [0:3] seq;
      int         gap;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[5];

   sipo_word_collector_if #(.WIDTH(4)) bus ();

   sipo_word_collector #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .sin     (sin),
      .sin_en  (sin_en),
      .clr     (clr),
      .bit_cnt (bit_cnt),
      .overrun (overrun),
      .out_if  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin    = b;
      sin_en = 1'b1;
      tick();
      sin_en = 1'b0;
   endtask

   task automatic send_word(input logic [0:3] seq, input int gap, input logic rdy_last, input logic par_flip);
      for (int i = 0; i < 4; i++) begin
`ifndef PARITY_CHECK_EN
         if (i == 3) bus.dout_ready = rdy_last;
`endif
         send_bit(seq[i]);
         bus.dout_ready = 1'b0;
         chk("bit_cnt_step", 32'(bit_cnt), 32'((i + 1) % 4));
         if (i < 3) for (int g = 0; g < gap; g++) tick();
      end
`ifdef PARITY_CHECK_EN
      bus.dout_ready = rdy_last;
      send_bit((^seq) ^ par_flip);
      bus.dout_ready = 1'b0;
`endif
   endtask

   task automatic pop_chk(input string name);
      logic [3:0] e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s: scoreboard empty, required an expected word", name);
      end else begin
         e = sb.pop_front();
         chk(name, 32'(bus.dout), 32'(e));
      end
   endtask

   task automatic consume(input string name);
      chk({name, "_valid"}, 32'(bus.dout_valid), 32'd1);
      pop_chk({name, "_dout"});
      bus.dout_ready = 1'b1;
      tick();
      bus.dout_ready = 1'b0;
      chk({name, "_valid_drop"}, 32'(bus.dout_valid), 32'd0);
   endtask

   initial begin
      vecs[0] = '{seq: 4'b1001, gap: 0, exp: 4'b1001};
      vecs[1] = '{seq: 4'b1001, gap: 1, exp: 4'b1001};
      vecs[2] = '{seq: 4'b1100, gap: 0, exp: 4'b0011};
      vecs[3] = '{seq: 4'b0111, gap: 2, exp: 4'b1110};
      vecs[4] = '{seq: 4'b1000, gap: 0, exp: 4'b0001};

      rst            = 1'b0;
      sin            = 1'b1;
      sin_en         = 1'b1;
      clr            = 1'b0;
      bus.dout_ready = 1'b0;
      tick();
      tick();
      chk("rst_dout",    32'(bus.dout),       32'd0);
      chk("rst_valid",   32'(bus.dout_valid), 32'd0);
      chk("rst_bit_cnt", 32'(bit_cnt),        32'd0);
      chk("rst_overrun", 32'(overrun),        32'd0);
      rst    = 1'b1;
      sin_en = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         send_word(vecs[v].seq, vecs[v].gap, 1'b0, 1'b0);
         sb.push_back(vecs[v].exp);
         consume("table");
      end

      send_bit(1'b1);
      send_bit(1'b1);
      chk("pre_clr_cnt", 32'(bit_cnt), 32'd2);
      clr    = 1'b1;
      sin    = 1'b1;
      sin_en = 1'b1;
      tick();
      clr    = 1'b0;
      sin_en = 1'b0;
      chk("clr_cnt",   32'(bit_cnt),        32'd0);
      chk("clr_valid", 32'(bus.dout_valid), 32'd0);
      send_word(4'b1011, 0, 1'b0, 1'b0);
      sb.push_back(4'b1101);
      consume("after_clr");

      send_word(4'b0101, 0, 1'b0, 1'b0);
      sb.push_back(4'hA);
      chk("ovr_before", 32'(overrun), 32'd0);
      send_word(4'b1010, 0, 1'b0, 1'b0);
      chk("ovr_set", 32'(overrun), 32'd1);
      consume("ovr_hold");
      tick();
      chk("ovr_sticky", 32'(overrun), 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("ovr_rst_clear", 32'(overrun), 32'd0);

      send_word(4'b0101, 0, 1'b0, 1'b0);
      sb.push_back(4'hA);
      pop_chk("b2b_first");
      send_word(4'b1010, 0, 1'b1, 1'b0);
      sb.push_back(4'h5);
      chk("b2b_overrun", 32'(overrun), 32'd0);
      consume("b2b_second");

      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midrst_cnt", 32'(bit_cnt), 32'd0);
      send_word(4'b0110, 0, 1'b0, 1'b0);
      sb.push_back(4'b0110);
      consume("midrst");

`ifdef PARITY_CHECK_EN
      send_word(4'b1100, 0, 1'b0, 1'b0);
      sb.push_back(4'b0011);
      chk("par_ok_err", 32'(bus.parity_err), 32'd0);
      consume("par_ok");
      send_word(4'b1100, 0, 1'b0, 1'b1);
      sb.push_back(4'b0011);
      chk("par_bad_err", 32'(bus.parity_err), 32'd1);
      consume("par_bad");
`endif

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
